wave_sample_capture: RTL and testbench
======================================

Name: wave_sample_capture

Overview:
- Writer side of the double-buffered 512x8 waveform sample RAM that the wave display block reads.
- Monitors the audio sample stream and arms on a rising zero-crossing.
- Writes 256 consecutive converted samples into the half of the RAM the display is not reading.
- Waits for the display to go idle, then flips `read_index` so the display draws the fresh capture.

Parameters:
- SAMPLE_WIDTH, 16: width of the signed two's-complement input sample.
- COUNT_WIDTH, 8: per-buffer address width; 2^COUNT_WIDTH samples are captured per buffer.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- sample_ready, input, 1: one-cycle strobe; new_sample_in is valid this cycle.
- new_sample_in, input, SAMPLE_WIDTH: signed audio sample.
- wave_display_idle, input, 1: level; high while the display is outside its drawing region.
- write_address, output, COUNT_WIDTH+1: RAM write address {~read_index, count}.
- write_enable, output, 1: one-cycle RAM write strobe.
- write_sample, output, 8: offset-binary sample byte.
- read_index, output, 1: buffer half the display reads; the writer always targets the other half.

Behaviour:
- Reset (async, active-high) drives:
  - state=ARMED, count=0, read_index=0, prev_sample=0.
  - write_enable=0, write_address=0, write_sample=0.
- Reset takes effect immediately, including mid-ACTIVE; any partial capture is abandoned and never displayed.
- Conversion: write_sample = {~s[SAMPLE_WIDTH-1], s[SAMPLE_WIDTH-2:SAMPLE_WIDTH-8]}.
  - Top 8 bits of the sample, with the sign bit inverted.
  - Examples: 0x8000->0x00, 0x0000->0x80, 0x7FFF->0xFF.
- prev_sample loads new_sample_in on every sample_ready, in every state.
- Rising zero-crossing = sample_ready && prev_sample MSB==1 && new_sample_in MSB==0.
- State ARMED:
  - No writes.
  - On a crossing: go to ACTIVE with count=0.
  - The crossing sample itself is not written.
- State ACTIVE, on each sample_ready:
  - Register write_address={~read_index,count}, write_sample=converted, write_enable=1 for exactly the next cycle.
  - Increment count.
  - When count==2^COUNT_WIDTH-1 is written: count wraps to 0 and state goes to WAIT.
  - Without sample_ready, write_enable=0 and count holds.
- Write latency: exactly 1 cycle from the sample_ready edge to write_enable high. Address and data are stable while write_enable is high.
- State WAIT:
  - sample_ready is ignored apart from the prev_sample update.
  - When wave_display_idle==1: toggle read_index and go to ARMED in the same edge.
  - If idle is already high on entry, the flip happens on the next clock.
- read_index changes only on the WAIT->ARMED transition, so the display never observes a half-written buffer.
- After a flip, a new crossing needs a fresh negative->non-negative pair.
- Simultaneous cases:
  - A crossing strobe arriving in WAIT or ACTIVE does not restart capture.
  - A sample_ready in the same cycle as the WAIT->ARMED flip updates prev_sample only; no crossing check is made in WAIT.
- Free-running counters wrap modulo 2^COUNT_WIDTH. There is no overflow beyond the 256th write.

Decomposition:
- Shared package wave_pkg holds:
  - state encoding constants ARMED=2'd0, ACTIVE=2'd1, WAIT=2'd2;
  - WAVE_RAM_ADDR_WIDTH=9 and WAVE_SAMPLE_BITS=8, shared with the display block.
- Registers use the existing dffr/dffre flip-flop primitives.
- One natural sub-module: zero_cross_detector.
  - Contains prev_sample and the crossing logic.
  - Interface: clk, reset, sample_ready, new_sample_in -> crossing.
- The FSM, counter and conversion stay in the top module.

Test Plan:
- Reset then idle: hold sample_ready=0 for 20 cycles -> write_enable stays 0, read_index=0, state ARMED.
- Crossing and capture:
  - Stimulus: samples 0xF000 then 0x0100, then 256 strobes of 0x0000, every 4th cycle.
  - Required: no write for 0x0100; 256 write_enable pulses at addresses 0x100..0x1FF with data 0x80, each 1 cycle after its strobe.
- No false trigger: strobes 0x0100, 0x0200, 0x7FFF (all positive) -> no writes, stays ARMED.
- WAIT and flip:
  - Stimulus: after a full capture, hold wave_display_idle=0 for 50 cycles with more crossings, then raise it.
  - Required: no writes during WAIT; read_index 0->1 one edge after idle rises.
  - Required: the next capture writes addresses 0x000..0x0FF.
- Conversion: during ACTIVE, drive 0x8000, 0x7FFF, 0xC000 -> write_sample 0x00, 0xFF, 0x40.
- Mid-capture reset: assert reset asynchronously after 100 writes -> write_enable drops at once, read_index=0, next capture starts again at address 0x100, count 0.

Source files
------------

// File: rtl/wave_pkg.sv
// ---------------------------------------------------------------------------
// wave_pkg
// Definitions shared by the waveform capture writer and the wave display
// reader: the capture FSM state encoding and the geometry of the
// double-buffered 512x8 sample RAM.
// ---------------------------------------------------------------------------
package wave_pkg;

   // RAM geometry: one buffer-select bit above an 8-bit per-buffer address.
   localparam int WAVE_RAM_ADDR_WIDTH = 9;
   localparam int WAVE_SAMPLE_BITS    = 8;

   // Capture FSM states.
   typedef enum logic [1:0] {
      ARMED  = 2'd0,
      ACTIVE = 2'd1,
      WAIT   = 2'd2
   } wave_state_t;

endpackage

// File: rtl/zero_cross_detector.sv
// ---------------------------------------------------------------------------
// zero_cross_detector
// Remembers the sign of the most recent audio sample. Flags a rising
// zero-crossing when a strobed sample is non-negative and the previous one
// was negative.
//
// Ports:
//   clk, reset     - system clock, asynchronous active-high reset
//   sample_ready   - one-cycle strobe qualifying new_sample_in
//   new_sample_in  - signed two's-complement audio sample
//   crossing       - combinational, high in the strobe cycle of a crossing
// ---------------------------------------------------------------------------
module zero_cross_detector #(
   parameter int SAMPLE_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    sample_ready,
   input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
   output logic                    crossing
);

   // Only the sign of the previous sample matters for the crossing decision,
   // so that is all that is kept.
   logic prev_sign_r;
   logic unused_low_bits_s;

   assign unused_low_bits_s = ^new_sample_in[SAMPLE_WIDTH-2:0];

   // Previous-sample sign register, updated on every strobe in every state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_sign_r <= 1'b0;
      end else if (sample_ready) begin
         prev_sign_r <= new_sample_in[SAMPLE_WIDTH-1];
      end else begin
         prev_sign_r <= prev_sign_r;
      end
   end

   assign crossing = sample_ready & prev_sign_r & ~new_sample_in[SAMPLE_WIDTH-1];

endmodule

// File: rtl/wave_sample_capture.sv
// ---------------------------------------------------------------------------
// wave_sample_capture
// Writer side of the double-buffered waveform RAM. Arms on a rising
// zero-crossing, then writes 2^COUNT_WIDTH converted samples into the half
// the display is not reading. It then waits for the display to go idle and
// flips read_index so the fresh capture is shown.
//
// Ports:
//   clk, reset         - system clock, asynchronous active-high reset
//   sample_ready       - one-cycle strobe qualifying new_sample_in
//   new_sample_in      - signed audio sample
//   wave_display_idle  - high while the display is outside its drawing area
//   write_address      - RAM write address {~read_index, count}
//   write_enable       - one-cycle RAM write strobe
//   write_sample       - offset-binary sample byte
//   read_index         - buffer half currently owned by the display
// ---------------------------------------------------------------------------
module wave_sample_capture
   import wave_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 16,
   parameter int COUNT_WIDTH  = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        sample_ready,
   input  logic [SAMPLE_WIDTH-1:0]     new_sample_in,
   input  logic                        wave_display_idle,
   output logic [COUNT_WIDTH:0]        write_address,
   output logic                        write_enable,
   output logic [WAVE_SAMPLE_BITS-1:0] write_sample,
   output logic                        read_index
);

   // Signed sample -> unsigned display byte: keep the top bits and flip the
   // sign so the most negative value maps to 0 and zero maps to mid-scale.
   function automatic logic [WAVE_SAMPLE_BITS-1:0] to_offset_binary(
      input logic [WAVE_SAMPLE_BITS-1:0] top_bits
   );
      return {~top_bits[WAVE_SAMPLE_BITS-1], top_bits[WAVE_SAMPLE_BITS-2:0]};
   endfunction

   wave_state_t                 state_r;
   logic [COUNT_WIDTH-1:0]      count_r;
   logic                        read_index_r;
   logic                        write_enable_r;
   logic [COUNT_WIDTH:0]        write_address_r;
   logic [WAVE_SAMPLE_BITS-1:0] write_sample_r;
   logic                        crossing_s;
   logic [WAVE_SAMPLE_BITS-1:0] sample_top_s;
   logic                        unused_low_bits_s;

   assign sample_top_s      = new_sample_in[SAMPLE_WIDTH-1 -: WAVE_SAMPLE_BITS];
   assign unused_low_bits_s = ^new_sample_in[SAMPLE_WIDTH-WAVE_SAMPLE_BITS-1:0];

   zero_cross_detector #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH)
   ) u_zero_cross_detector (
      .clk           (clk),
      .reset         (reset),
      .sample_ready  (sample_ready),
      .new_sample_in (new_sample_in),
      .crossing      (crossing_s)
   );

   // Capture FSM with counter, buffer select and registered RAM write port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r         <= ARMED;
         count_r         <= {COUNT_WIDTH{1'b0}};
         read_index_r    <= 1'b0;
         write_enable_r  <= 1'b0;
         write_address_r <= {(COUNT_WIDTH+1){1'b0}};
         write_sample_r  <= {WAVE_SAMPLE_BITS{1'b0}};
      end else begin
         case (state_r)
            ARMED: begin
               write_enable_r <= 1'b0;
               // The crossing sample itself is not written; capture starts
               // with the next strobe.
               if (crossing_s) begin
                  state_r <= ACTIVE;
                  count_r <= {COUNT_WIDTH{1'b0}};
               end else begin
                  state_r <= ARMED;
               end
            end
            ACTIVE: begin
               if (sample_ready) begin
                  write_enable_r  <= 1'b1;
                  write_address_r <= {~read_index_r, count_r};
                  write_sample_r  <= to_offset_binary(sample_top_s);
                  count_r         <= count_r + COUNT_WIDTH'(1'b1);
                  // Last slot of the buffer written: the counter wraps to 0.
                  if (&count_r) begin
                     state_r <= WAIT;
                  end else begin
                     state_r <= ACTIVE;
                  end
               end else begin
                  write_enable_r <= 1'b0;
               end
            end
            WAIT: begin
               write_enable_r <= 1'b0;
               // Hand the finished buffer to the display only between frames.
               if (wave_display_idle) begin
                  read_index_r <= ~read_index_r;
                  state_r      <= ARMED;
               end else begin
                  state_r <= WAIT;
               end
            end
            default: begin
               state_r        <= ARMED;
               write_enable_r <= 1'b0;
            end
         endcase
      end
   end

   assign write_address = write_address_r;
   assign write_enable  = write_enable_r;
   assign write_sample  = write_sample_r;
   assign read_index    = read_index_r;

endmodule

// File: tb/tb_wave_sample_capture.sv
// ---------------------------------------------------------------------------
// tb_wave_sample_capture
// Drives the capture block with directed and random sample streams. Compares
// every cycle against a behavioural model of the capture rules.
// ---------------------------------------------------------------------------
module tb_wave_sample_capture;

   logic        clk;
   logic        reset;
   logic        sample_ready;
   logic [15:0] new_sample_in;
   logic        wave_display_idle;
   logic [8:0]  write_address;
   logic        write_enable;
   logic [7:0]  write_sample;
   logic        read_index;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   bit         m_capturing;
   bit         m_waiting;
   bit         m_prev_neg;
   bit         m_ri;
   int         m_n;
   bit         exp_we;
   logic [8:0] exp_addr;
   logic [7:0] exp_data;

   typedef struct {
      bit          sr;
      logic [15:0] s;
   } stim_t;

   stim_t q[$];

   wave_sample_capture dut (
      .clk               (clk),
      .reset             (reset),
      .sample_ready      (sample_ready),
      .new_sample_in     (new_sample_in),
      .wave_display_idle (wave_display_idle),
      .write_address     (write_address),
      .write_enable      (write_enable),
      .write_sample      (write_sample),
      .read_index        (read_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_capturing = 1'b0;
      m_waiting   = 1'b0;
      m_prev_neg  = 1'b0;
      m_ri        = 1'b0;
      m_n         = 0;
      exp_we      = 1'b0;
   endtask

   // Effect of one clock edge on the model, given the inputs at that edge.
   task automatic model_edge(input bit sr, input logic [15:0] s, input bit idle);
      exp_we = 1'b0;
      if (m_waiting) begin
         if (idle) begin
            m_ri      = !m_ri;
            m_waiting = 1'b0;
         end
      end else if (m_capturing) begin
         if (sr) begin
            exp_we   = 1'b1;
            exp_addr = 9'((m_ri ? 0 : 256) + m_n);
            exp_data = 8'((s >> 8) ^ 16'h0080);
            m_n      = m_n + 1;
            if (m_n == 256) begin
               m_n         = 0;
               m_capturing = 1'b0;
               m_waiting   = 1'b1;
            end
         end
      end else if (sr && m_prev_neg && !s[15]) begin
         m_capturing = 1'b1;
         m_n         = 0;
      end
      if (sr) m_prev_neg = s[15];
   endtask

   task automatic push(input logic [15:0] s, input int gap);
      stim_t e;
      e.sr = 1'b1;
      e.s  = s;
      q.push_back(e);
      for (int i = 0; i < gap; i++) begin
         e.sr = 1'b0;
         e.s  = 16'h0000;
         q.push_back(e);
      end
   endtask

   // One clock: drive at the falling edge, then sample 1 time unit after the rising edge.
   task automatic step(input bit sr, input logic [15:0] s);
      @(negedge clk);
      sample_ready  = sr;
      new_sample_in = s;
      @(posedge clk);
      model_edge(sr, s, wave_display_idle);
      #1;
   endtask

   task automatic test_reset();
      wave_display_idle = 1'b0;
      sample_ready      = 1'b0;
      new_sample_in     = 16'h0000;
      reset             = 1'b1;
      model_reset();
      #3;
      checks++;
      if (write_enable !== 1'b0 || read_index !== 1'b0 ||
          write_address !== 9'h000 || write_sample !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got we=%b ri=%b addr=%h data=%h, need all zero",
                  write_enable, read_index, write_address, write_sample);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 16'h0000);
         checks++;
         if (write_enable !== 1'b0 || read_index !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: cycle %0d got we=%b ri=%b, need 0 0",
                     i, write_enable, read_index);
         end
      end
   endtask

   task automatic test_no_false_trigger();
      q.delete();
      push(16'h0100, 2);
      push(16'h0200, 2);
      push(16'h7FFF, 4);
      foreach (q[i]) begin
         step(q[i].sr, q[i].s);
         checks++;
         if (write_enable !== 1'b0 || write_enable !== exp_we) begin
            errors++;
            $display("FAIL no_false_trigger: step %0d got we=%b, need 0", i, write_enable);
         end
      end
   endtask

   task automatic test_capture();
      int pulses = 0;
      logic [8:0] first_addr = 9'h000;
      logic [8:0] last_addr  = 9'h000;
      q.delete();
      push(16'hF000, 3);
      push(16'h0100, 3);
      for (int i = 0; i < 256; i++) push(16'h0000, 3);
      foreach (q[i]) begin
         step(q[i].sr, q[i].s);
         checks++;
         if (write_enable !== exp_we) begin
            errors++;
            $display("FAIL capture_we: step %0d got %b need %b", i, write_enable, exp_we);
         end
         if (exp_we) begin
            checks++;
            if (write_address !== exp_addr || write_sample !== exp_data) begin
               errors++;
               $display("FAIL capture_write: got addr=%h data=%h need addr=%h data=%h",
                        write_address, write_sample, exp_addr, exp_data);
            end
         end
         if (write_enable === 1'b1) begin
            if (pulses == 0) first_addr = write_address;
            last_addr = write_address;
            pulses++;
         end
      end
      checks++;
      if (pulses != 256 || first_addr !== 9'h100 || last_addr !== 9'h1FF) begin
         errors++;
         $display("FAIL capture_span: got %0d writes %h..%h, need 256 writes 100..1ff",
                  pulses, first_addr, last_addr);
      end
   endtask

   task automatic test_wait_flip();
      int pulses = 0;
      logic [8:0] first_addr = 9'h1FF;
      logic [8:0] last_addr  = 9'h1FF;
      wave_display_idle = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step(1'b1, (i % 2 == 0) ? 16'hF000 : 16'h0100);
         checks++;
         if (write_enable !== 1'b0 || read_index !== m_ri) begin
            errors++;
            $display("FAIL wait_hold: cycle %0d got we=%b ri=%b need 0 %b",
                     i, write_enable, read_index, m_ri);
         end
      end
      wave_display_idle = 1'b1;
      step(1'b0, 16'h0000);
      checks++;
      if (read_index !== 1'b1 || read_index !== m_ri) begin
         errors++;
         $display("FAIL wait_flip: got ri=%b need 1", read_index);
      end
      q.delete();
      push(16'h8000 | 16'($urandom_range(0, 32767)), $urandom_range(0, 2));
      push(16'($urandom_range(0, 32767)), $urandom_range(0, 2));
      for (int i = 0; i < 256; i++) push(16'($urandom), $urandom_range(0, 2));
      push(16'h0000, 2);
      foreach (q[i]) begin
         step(q[i].sr, q[i].s);
         checks++;
         if (write_enable !== exp_we || read_index !== m_ri) begin
            errors++;
            $display("FAIL second_capture_ctl: step %0d got we=%b ri=%b need %b %b",
                     i, write_enable, read_index, exp_we, m_ri);
         end
         if (exp_we) begin
            checks++;
            if (write_address !== exp_addr || write_sample !== exp_data) begin
               errors++;
               $display("FAIL second_capture_write: got addr=%h data=%h need addr=%h data=%h",
                        write_address, write_sample, exp_addr, exp_data);
            end
         end
         if (write_enable === 1'b1) begin
            if (pulses == 0) first_addr = write_address;
            last_addr = write_address;
            pulses++;
         end
      end
      checks++;
      if (pulses != 256 || first_addr !== 9'h000 || last_addr !== 9'h0FF) begin
         errors++;
         $display("FAIL second_capture_span: got %0d writes %h..%h, need 256 writes 000..0ff",
                  pulses, first_addr, last_addr);
      end
   endtask

   task automatic test_conversion();
      logic [7:0] conv_exp [3];
      int idx = 0;
      conv_exp[0] = 8'h00;
      conv_exp[1] = 8'hFF;
      conv_exp[2] = 8'h40;
      q.delete();
      push(16'hFFFF, 1);
      push(16'h0000, 1);
      push(16'h8000, 1);
      push(16'h7FFF, 1);
      push(16'hC000, 1);
      for (int i = 0; i < 253; i++) push(16'($urandom), $urandom_range(0, 1));
      push(16'h0000, 2);
      foreach (q[i]) begin
         step(q[i].sr, q[i].s);
         checks++;
         if (write_enable !== exp_we || read_index !== m_ri) begin
            errors++;
            $display("FAIL conv_ctl: step %0d got we=%b ri=%b need %b %b",
                     i, write_enable, read_index, exp_we, m_ri);
         end
         if (exp_we) begin
            checks++;
            if (write_address !== exp_addr || write_sample !== exp_data) begin
               errors++;
               $display("FAIL conv_write: got addr=%h data=%h need addr=%h data=%h",
                        write_address, write_sample, exp_addr, exp_data);
            end
         end
         if (write_enable === 1'b1 && idx < 3) begin
            checks++;
            if (write_sample !== conv_exp[idx]) begin
               errors++;
               $display("FAIL conv_value: write %0d got %h need %h", idx, write_sample, conv_exp[idx]);
            end
            idx++;
         end
      end
   endtask

   task automatic test_mid_reset();
      int pulses = 0;
      bit seen_first = 1'b0;
      q.delete();
      push(16'hF000, 1);
      push(16'h0100, 1);
      for (int i = 0; i < 150; i++) push(16'($urandom), 1);
      foreach (q[i]) begin
         step(q[i].sr, q[i].s);
         checks++;
         if (write_enable !== exp_we) begin
            errors++;
            $display("FAIL midreset_we: step %0d got %b need %b", i, write_enable, exp_we);
         end
         if (write_enable === 1'b1) pulses++;
         if (pulses == 100) break;
      end
      checks++;
      if (pulses != 100 || read_index !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pre: got %0d writes ri=%b need 100 writes ri=1", pulses, read_index);
      end
      // Reset arrives between clock edges while a write strobe is high.
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if (write_enable !== 1'b0 || read_index !== 1'b0 || write_address !== 9'h000) begin
         errors++;
         $display("FAIL midreset_async: got we=%b ri=%b addr=%h need 0 0 000",
                  write_enable, read_index, write_address);
      end
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      push(16'hF000, 1);
      push(16'h0100, 1);
      for (int i = 0; i < 6; i++) push(16'($urandom), 1);
      foreach (q[i]) begin
         step(q[i].sr, q[i].s);
         checks++;
         if (write_enable !== exp_we) begin
            errors++;
            $display("FAIL restart_we: step %0d got %b need %b", i, write_enable, exp_we);
         end
         if (exp_we) begin
            checks++;
            if (write_address !== exp_addr || write_sample !== exp_data) begin
               errors++;
               $display("FAIL restart_write: got addr=%h data=%h need addr=%h data=%h",
                        write_address, write_sample, exp_addr, exp_data);
            end
            if (!seen_first) begin
               checks++;
               if (write_address !== 9'h100) begin
                  errors++;
                  $display("FAIL restart_first_addr: got %h need 100", write_address);
               end
               seen_first = 1'b1;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_no_false_trigger();
      test_capture();
      test_wait_flip();
      test_conversion();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
